// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and stores on a word RAM; ack 1 cycle after req, or 1+WAIT_CYCLES with `DMEM_WAIT_EN`.
// One request in flight; the requester stalls on req & ~ack, and a request still high during ack is never re-accepted.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        write,
  input  logic [31:0] wdata,
  input  logic        extend,
  input  logic [1:0]  width,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH);

`ifdef DMEM_WAIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_t;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CW-1:0] cnt_q;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd2} state_t;
  localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

  state_t          state_q, state_d;
  logic [31:0]     mem [DEPTH];
  logic [31:0]     ram_q;
  logic [AW-1:0]   idx_q;
  logic [1:0]      off_q, width_q;
  logic            ext_q, wr_q, flt_q;
  logic            misalign, accept, commit;
  logic [3:0]      be;
  logic [31:0]     wlane, shifted, ld;
  logic            unused_addr;

  assign unused_addr = ^addr[31:AW+2];
  assign accept      = (state_q == IDLE) && req;

  always_comb begin
    misalign = 1'b0;
    case (width)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = addr[0];
      2'd2:    misalign = |addr[1:0];
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
`ifdef DMEM_WAIT_EN
          state_d = (WAIT_CYCLES != 0) ? WAIT : ACK;
`else
          state_d = ACK;
`endif
        end
      end
`ifdef DMEM_WAIT_EN
      WAIT: begin
        // A dropped req mid-wait is a protocol violation: abandon silently.
        if (!req)                     state_d = IDLE;
        else if (cnt_q == CW'(1))     state_d = ACK;
      end
`endif
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

`ifdef DMEM_WAIT_EN
  always_ff @(posedge clk) begin
    if (reset)                 cnt_q <= '0;
    else if (accept)           cnt_q <= CW'(WAIT_CYCLES);
    else if (state_q == WAIT)  cnt_q <= cnt_q - 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= addr[AW+1:2];
      off_q   <= addr[1:0];
      width_q <= width;
      ext_q   <= extend;
      wr_q    <= write;
      flt_q   <= misalign;
      ram_q   <= mem[addr[AW+1:2]];
    end
  end

  always_comb begin
    be    = 4'b0000;
    wlane = wdata;
    case (width_q)
      2'd0: begin
        be    = 4'b0001 << off_q;
        wlane = {4{wdata[7:0]}};
      end
      2'd1: begin
        be    = off_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
      end
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Commit on the edge closing ACK; a reset on that edge drops the store.
  assign commit = (state_q == ACK) && !reset && wr_q && !flt_q;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_comb begin
    shifted = ram_q >> {off_q, 3'b000};
    ld      = 32'h0;
    case (width_q)
      2'd0:    ld = ext_q ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
      2'd1:    ld = ext_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
      2'd2:    ld = ram_q;
      default: ld = 32'h0;
    endcase
  end

  assign ack   = (state_q == ACK);
  assign fault = ack && flt_q;
  assign rdata = (ack && !wr_q && !flt_q) ? ld : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: issuer pushes expected {fault, rdata}; a negedge monitor pops on every ack.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset, req, write, extend;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  width;
  logic        ack, fault;

`ifdef DMEM_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int ack_cyc = 0;
  logic [32:0] exp_q[$];

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .write(write),
    .wdata(wdata), .extend(extend), .width(width),
    .ack(ack), .rdata(rdata), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL spurious_ack at cycle %0d: got ack=1, required no ack", cyc);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("fault", {31'h0, fault}, {31'h0, e[32]});
        check("rdata", rdata, e[31:0]);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after ack.
  task automatic access(input string name, input logic wr, input logic [1:0] wd, input logic ext,
                        input logic [31:0] a, input logic [31:0] wdat,
                        input logic ef, input logic [31:0] er);
    int k;
    bit got;
    exp_q.push_back({ef, er});
    req = 1'b1; write = wr; width = wd; extend = ext; addr = a; wdata = wdat;
    got = 0;
    k = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (ack === 1'b1) got = 1;
    end
    if (!got) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: got no ack in 20 cycles, required ack after %0d", name, 1 + W);
      exp_q.delete();
    end else begin
      check({name, "_lat"}, 32'(k - 1), 32'(1 + W));
      ack_cyc = cyc;
    end
    @(posedge clk);
    #1;
    req = 1'b0; write = 1'b0;
  endtask

  task automatic expect_no_ack(input string name, input int cycles);
    int nacks;
    nacks = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (ack === 1'b1) nacks++;
    end
    check(name, 32'(nacks), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a1;
    reset = 1'b1; req = 1'b0; write = 1'b0; extend = 1'b0;
    addr = 32'h0; wdata = 32'h0; width = 2'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_ack", {31'h0, ack}, 32'h0);
    check("reset_fault", {31'h0, fault}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    @(posedge clk);
    #1;

    // name, write, width, extend, addr, wdata, exp fault, exp rdata
    access("st_w100",   1, 2'd2, 0, 32'h100,  32'hDEADBEEF, 0, 32'h0);
    access("ld_w100",   0, 2'd2, 0, 32'h100,  32'h0,        0, 32'hDEADBEEF);
    access("ld_b103s",  0, 2'd0, 1, 32'h103,  32'h0,        0, 32'hFFFFFFDE);
    access("ld_b103z",  0, 2'd0, 0, 32'h103,  32'h0,        0, 32'h000000DE);
    access("ld_h100s",  0, 2'd1, 1, 32'h100,  32'h0,        0, 32'hFFFFBEEF);
    access("ld_h102z",  0, 2'd1, 0, 32'h102,  32'h0,        0, 32'h0000DEAD);
    access("ld_b100s",  0, 2'd0, 1, 32'h100,  32'h0,        0, 32'hFFFFFFEF);
    access("ld_w100x",  0, 2'd2, 1, 32'h100,  32'h0,        0, 32'hDEADBEEF);
    access("st_w200",   1, 2'd2, 0, 32'h200,  32'h00000000, 0, 32'h0);
    access("st_b202",   1, 2'd0, 0, 32'h202,  32'h123456A5, 0, 32'h0);
    access("ld_w200a",  0, 2'd2, 0, 32'h200,  32'h0,        0, 32'h00A50000);
    access("st_w201",   1, 2'd2, 0, 32'h201,  32'h12345678, 1, 32'h0);
    access("ld_w200b",  0, 2'd2, 0, 32'h200,  32'h0,        0, 32'h00A50000);
    access("ld_h203",   0, 2'd1, 1, 32'h203,  32'h0,        1, 32'h0);
    access("ld_res",    0, 2'd3, 0, 32'h200,  32'h0,        1, 32'h0);
    access("st_h202",   1, 2'd1, 0, 32'h202,  32'hABCD7FFF, 0, 32'h0);
    access("ld_w200c",  0, 2'd2, 0, 32'h200,  32'h0,        0, 32'h7FFF0000);
    access("st_w1000",  1, 2'd2, 0, 32'h1000, 32'h11111111, 0, 32'h0);

    // Back-to-back: second request lands in the IDLE cycle right after the first ack.
    access("ld_w0",     0, 2'd2, 0, 32'h0,    32'h0,        0, 32'h11111111);
    a1 = ack_cyc;
    access("ld_w100b",  0, 2'd2, 0, 32'h100,  32'h0,        0, 32'hDEADBEEF);
    check("b2b_gap", 32'(ack_cyc - a1), 32'(2 + W));

    // Reset during an in-flight store to 0x300 must drop the store.
    access("st_w300",   1, 2'd2, 0, 32'h300,  32'hCAFEF00D, 0, 32'h0);
    req = 1'b1; write = 1'b1; width = 2'd2; extend = 1'b0; addr = 32'h300; wdata = 32'h55555555;
`ifndef DMEM_WAIT_EN
    exp_q.push_back({1'b0, 32'h0});
`endif
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; req = 1'b0; write = 1'b0;
    expect_no_ack("abort_no_ack", 6);
    access("ld_w300",   0, 2'd2, 0, 32'h300,  32'h0,        0, 32'hCAFEF00D);

`ifdef DMEM_WAIT_EN
    // Dropping req mid-wait abandons the request without an ack.
    req = 1'b1; write = 1'b1; width = 2'd2; addr = 32'h100; wdata = 32'h0BADF00D;
    @(posedge clk);
    #1 req = 1'b0; write = 1'b0;
    expect_no_ack("drop_no_ack", 6);
    access("ld_after_drop", 0, 2'd2, 0, 32'h100, 32'h0,    0, 32'hDEADBEEF);
`endif

    repeat (5) @(posedge clk);
    check("pending_expect", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the memory stage's request/acknowledge port. It owns a word-organised synchronous RAM and serves byte, halfword and word loads and stores, one request at a time. On each request it raises `ack` after a fixed latency. Load data is returned right-justified and sign- or zero-extended. The memory stage stalls on `req & ~ack` and captures `rdata` on the edge where `ack` is high.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words; power of two.
- `WAIT_CYCLES`, 2: extra wait states before `ack`; only honoured with `DMEM_WAIT_EN`.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: reset. Synchronous and active-high. Returns the FSM to IDLE; RAM contents are unaffected.
- `req` in 1: access request; held with all request fields stable until the `ack` cycle.
- `addr` in 32: byte address. Bits [log2(DEPTH)+1:2] select the word; higher bits are ignored, so addresses wrap modulo 4*DEPTH.
- `write` in 1: 1 = store, 0 = load.
- `wdata` in 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `extend` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `width` in 2: 0 = byte, 1 = halfword, 2 = word, 3 = reserved.
- `ack` out 1: registered; high for exactly one cycle per accepted request.
- `rdata` out 32: load result; valid only while `ack=1` and `write=0`; 0 otherwise.
- `fault` out 1: high with `ack` when the access is misaligned or `width=3`.

## Operation
- The FSM has three states: IDLE, WAIT and ACK. Reset puts it in IDLE with `ack=0`, `fault=0`, `rdata=0`, and the wait counter at 0.
- **IDLE:**
  - If `req=0`, stay in IDLE.
  - If `req=1`, latch `addr[1:0]`, `width`, `extend`, `write` and the alignment check. Issue the RAM read of the addressed word.
  - Go to WAIT if the effective wait count is nonzero; otherwise go to ACK.
- **WAIT:**
  - Decrement the counter; the RAM output register holds its value.
  - When the counter reaches 1, go to ACK.
  - If `req` drops (a protocol violation), abandon the request: go to IDLE, no write, no `ack`.
- **ACK:**
  - `ack=1` for this cycle. On the closing edge, a store that is not faulted commits its byte enables. Go to IDLE unconditionally.
  - A `req` still high in this cycle belongs to the completed transfer and is not re-accepted.
- **Alignment:**
  - Byte accesses are always aligned.
  - Halfword accesses need `addr[0]=0`.
  - Word accesses need `addr[1:0]=0`.
- **Faulted access:** the store is suppressed, `rdata=0`, `fault=1` with `ack`. Latency is unchanged.
- **Store lanes:**
  - Byte: `wdata[7:0]` goes to lane `addr[1:0]`.
  - Halfword: `wdata[15:0]` goes to lanes `addr[1]*2` and `addr[1]*2+1`.
  - Word: all four lanes.
  - Untouched lanes keep their contents.
- **Load:**
  - Shift the RAM word right by 8*`addr[1:0]`.
  - Mask to the access width.
  - If `extend=1`, replicate bit 7 (byte) or bit 15 (halfword).
  - Word loads ignore `extend`.
- Reset in WAIT or ACK aborts the transfer: the pending store is dropped and `ack` is 0 in the next cycle.

## Timing
- With `req` first high in cycle N, `ack` is high in cycle N+1+W.
  - W = `WAIT_CYCLES` when `DMEM_WAIT_EN` is defined, else 0.
- The store commits on the rising edge that ends cycle N+1+W.
- The earliest next acceptance is cycle N+2+W (the IDLE cycle), with `ack` in N+3+W. Peak throughput is one access per 2+W cycles.
- `ack`, `fault` and `rdata` are all driven from registers or from the RAM output register plus the extend logic. There is no combinational path from `req` to `ack`.
- A load following a store to the same word sees the new data, because the write commits before the next RAM read.

## Configuration
- `DMEM_WAIT_EN`: when defined, the WAIT state and counter are built and `ack` arrives `WAIT_CYCLES` cycles later. This exercises the requester's stall path.
- When not defined, the WAIT state and counter are removed and the FSM is IDLE→ACK→IDLE with fixed latency 1. `WAIT_CYCLES` is ignored.

## Test plan
- Word store then load: store `0xDEADBEEF` at 0x100, then load word at 0x100 → `rdata=0xDEADBEEF`, `fault=0`. Measure `ack` latency as 1 (no macro) or 3 (macro, W=2).
- Byte loads with sign handling: the word at 0x100 is `0xDEADBEEF`.
  - Load byte at 0x103 with `extend=1` → `0xFFFFFFDE`.
  - Same load with `extend=0` → `0x000000DE`.
  - Load half at 0x100 with `extend=1` → `0xFFFFBEEF`.
- Byte store merge: word `0x00000000` at 0x200, store byte `0xA5` at 0x202 → word load at 0x200 returns `0x00A50000`.
- Misaligned and reserved accesses:
  - Word store of `0x12345678` at 0x201 → `ack=1`, `fault=1`, and a later load at 0x200 is unchanged.
  - Half load at 0x203 → `fault=1`, `rdata=0`.
  - `width=3` → `fault=1`.
- Wrap and back-to-back (DEPTH=1024):
  - Store word `0x11111111` at 0x1000 → a load at 0x0 returns `0x11111111`.
  - Two consecutive requests produce exactly two `ack` pulses, at least 2+W cycles apart.
- Reset and abort:
  - Assert `reset` in the WAIT cycle of a store to 0x300 → no `ack` afterwards, and the word at 0x300 is unchanged.
  - Drop `req` mid-WAIT → return to IDLE with no `ack`.
